// File: rtl/btn_debounce_pkg.sv
// Shared types and elaboration-time helpers for the multi-button debouncer.
// Holds the clog2/divider helpers used to size counters in the top and channel modules.
package btn_debounce_pkg;

   typedef enum logic [1:0] {
      EV_NONE    = 2'd0,
      EV_PRESS   = 2'd1,
      EV_RELEASE = 2'd2
   } btn_event_e;

   localparam int MIN_WIDTH = 1;

   // Ceiling log2, never narrower than one bit so single-state counters stay legal.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return (w < MIN_WIDTH) ? MIN_WIDTH : w;
   endfunction

   function automatic int DIV_OF(input int clkHz, input int sampleHz);
      return clkHz / sampleHz;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stable-sample counter, level and edge pulses.
// Optional auto-repeat on held buttons when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_channel
   import btn_debounce_pkg::*;
#(
   parameter int STABLE_SAMPLES = 8,
   parameter int REPEAT_START   = 500,
   parameter int REPEAT_PERIOD  = 100
) (
   input  logic clock1,
   input  logic reset1,
   input  logic i_tick,
   input  logic i_button,
   output logic o_level,
   output logic o_pressed,
   output logic o_released
);

   localparam int CNT_W = clog2(STABLE_SAMPLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_pressed;
   logic             r_released;
   btn_event_e       w_event;

   // A level change is accepted on the tick that completes the run of agreeing samples.
   always_comb begin
      w_event = EV_NONE;
      if (i_tick && (r_sync2 != r_level) && (r_cnt == CNT_LAST)) begin
         w_event = r_sync2 ? EV_PRESS : EV_RELEASE;
      end
   end

   always_ff @(posedge clock1) begin
      if (reset1) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_cnt      <= '0;
         r_level    <= 1'b0;
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
      end else begin
         r_sync1    <= i_button;
         r_sync2    <= r_sync1;
         r_pressed  <= 1'b0;
         r_released <= 1'b0;
         if (i_tick) begin
            if (r_sync2 == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
               r_level <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
         case (w_event)
            EV_PRESS:   r_pressed  <= 1'b1;
            EV_RELEASE: r_released <= 1'b1;
            default:    ;
         endcase
      end
   end

   assign o_level    = r_level;
   assign o_released = r_released;

`ifdef BTN_AUTOREPEAT_EN
   localparam int REP_W = clog2(max2(REPEAT_START, REPEAT_PERIOD));

   logic [REP_W-1:0] r_rep;
   logic             r_repFirst;
   logic             r_repPulse;
   logic [REP_W-1:0] w_repLast;

   assign w_repLast = r_repFirst ? REP_W'(REPEAT_START - 1) : REP_W'(REPEAT_PERIOD - 1);

   // A release accepted on the same tick wins, so pressed and released never coincide.
   always_ff @(posedge clock1) begin
      if (reset1) begin
         r_rep      <= '0;
         r_repFirst <= 1'b1;
         r_repPulse <= 1'b0;
      end else begin
         r_repPulse <= 1'b0;
         if (!r_level || (w_event == EV_RELEASE)) begin
            r_rep      <= '0;
            r_repFirst <= 1'b1;
         end else if (i_tick) begin
            if (r_rep == w_repLast) begin
               r_rep      <= '0;
               r_repFirst <= 1'b0;
               r_repPulse <= 1'b1;
            end else begin
               r_rep <= r_rep + 1'b1;
            end
         end
      end
   end

   assign o_pressed = r_pressed | r_repPulse;
`else
   localparam int unusedRepeatCfg = REPEAT_START + REPEAT_PERIOD;

   assign o_pressed = r_pressed;
`endif

endmodule

// File: rtl/multi_btn_debouncer.sv
// N-channel push-button debouncer: shared sample-tick generator plus one channel per button.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses while a button is held.
module multi_btn_debouncer
   import btn_debounce_pkg::*;
#(
   parameter int NUM_BTNS       = 4,
   parameter int CLK_HZ         = 100000000,
   parameter int SAMPLE_HZ      = 1000,
   parameter int STABLE_SAMPLES = 8,
   parameter int REPEAT_START   = 500,
   parameter int REPEAT_PERIOD  = 100
) (
   input  logic                clock1,
   input  logic                reset1,
   input  logic [NUM_BTNS-1:0] buttons,
   output logic [NUM_BTNS-1:0] btn_level,
   output logic [NUM_BTNS-1:0] btn_pressed,
   output logic [NUM_BTNS-1:0] btn_released,
   output logic                sample_tick
);

   localparam int DIV    = DIV_OF(CLK_HZ, SAMPLE_HZ);
   localparam int TICK_W = clog2(DIV);

   logic [TICK_W-1:0] r_tickCnt;
   logic              r_tick;

   // The strobe is registered one count early so it is high exactly while the counter sits at DIV-1.
   always_ff @(posedge clock1) begin
      if (reset1) begin
         r_tickCnt <= '0;
         r_tick    <= 1'b0;
      end else begin
         r_tick <= (r_tickCnt == TICK_W'(DIV - 2));
         if (r_tickCnt == TICK_W'(DIV - 1)) begin
            r_tickCnt <= '0;
         end else begin
            r_tickCnt <= r_tickCnt + 1'b1;
         end
      end
   end

   assign sample_tick = r_tick;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
      btn_debounce_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES),
         .REPEAT_START   (REPEAT_START),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clock1     (clock1),
         .reset1     (reset1),
         .i_tick     (r_tick),
         .i_button   (buttons[g]),
         .o_level    (btn_level[g]),
         .o_pressed  (btn_pressed[g]),
         .o_released (btn_released[g])
      );
   end

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Scoreboard bench for multi_btn_debouncer with DIV=10, STABLE_SAMPLES=4, four channels.
// Expected pulse windows are queued when buttons change and retired when the DUT pulses.
module tb_multi_btn_debouncer;

   localparam int N       = 4;
   localparam int DIV     = 10;
   localparam int SS      = 4;
   localparam int LAT_MIN = 2 + 0 + (SS - 1) * DIV + 1;
   localparam int LAT_MAX = 2 + (DIV - 1) + (SS - 1) * DIV + 1;

   typedef struct {
      int ch;
      bit isPress;
      int earliest;
      int latest;
   } expEvent_t;

   logic         clock1 = 1'b0;
   logic         reset1;
   logic [N-1:0] buttons;
   logic [N-1:0] btn_level;
   logic [N-1:0] btn_pressed;
   logic [N-1:0] btn_released;
   logic         sample_tick;

   int           cycle = 0;
   int           passCount = 0;
   int           checkCount = 0;
   bit           monitorOn = 1'b0;
   logic [N-1:0] prevLevel = '0;
   expEvent_t    sbQueue[$];

   multi_btn_debouncer #(
      .NUM_BTNS       (N),
      .CLK_HZ         (100),
      .SAMPLE_HZ      (10),
      .STABLE_SAMPLES (SS),
      .REPEAT_START   (5),
      .REPEAT_PERIOD  (2)
   ) dut (
      .clock1       (clock1),
      .reset1       (reset1),
      .buttons      (buttons),
      .btn_level    (btn_level),
      .btn_pressed  (btn_pressed),
      .btn_released (btn_released),
      .sample_tick  (sample_tick)
   );

   always #5 clock1 = ~clock1;

   always @(posedge clock1) cycle <= cycle + 1;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
   endtask

   task automatic expectEvent(input int ch, input bit isPress, input int earliest, input int latest);
      expEvent_t e;
      e.ch = ch;
      e.isPress = isPress;
      e.earliest = earliest;
      e.latest = latest;
      sbQueue.push_back(e);
   endtask

   task automatic matchEvent(input int ch, input bit isPress);
      int found;
      int inWin;
      found = 0;
      for (int k = 0; k < sbQueue.size(); k++) begin
         if (found == 0 && sbQueue[k].ch == ch && sbQueue[k].isPress == isPress) begin
            found = 1;
            inWin = (cycle >= sbQueue[k].earliest && cycle <= sbQueue[k].latest) ? 1 : 0;
            checkOutput($sformatf("%s_ch%0d_cycle%0d_window%0d..%0d", isPress ? "press" : "release",
                        ch, cycle, sbQueue[k].earliest, sbQueue[k].latest), inWin, 1);
            sbQueue.delete(k);
            break;
         end
      end
      if (found == 0)
         checkOutput($sformatf("unexpected_%s_ch%0d_cycle%0d", isPress ? "press" : "release", ch, cycle), found, 1);
   endtask

   // Monitor: retire scoreboard entries on pulses and tie every level change to a pulse.
   always @(negedge clock1) begin
      if (monitorOn && reset1 === 1'b0) begin
         for (int ch = 0; ch < N; ch++) begin
            if (btn_level[ch] != prevLevel[ch])
               checkOutput($sformatf("level_change_pulse_ch%0d", ch), int'(btn_pressed[ch] | btn_released[ch]), 1);
            if (btn_pressed[ch]) begin
               matchEvent(ch, 1'b1);
               checkOutput($sformatf("press_level_ch%0d", ch), int'(btn_level[ch]), 1);
               checkOutput($sformatf("press_excl_ch%0d", ch), int'(btn_released[ch]), 0);
            end
            if (btn_released[ch]) begin
               matchEvent(ch, 1'b0);
               checkOutput($sformatf("release_level_ch%0d", ch), int'(btn_level[ch]), 0);
            end
         end
      end
      prevLevel = btn_level;
   end

   task automatic applyStimulus(input logic [N-1:0] value);
      buttons = value;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock1);
   endtask

   initial begin
      int n;
      int c;
      reset1 = 1'b1;
      buttons = 4'b1111;
      monitorOn = 1'b1;

      repeat (5) begin
         @(negedge clock1);
         checkOutput("reset_outputs", int'({btn_level, btn_pressed, btn_released, sample_tick}), 0);
      end

      // Release reset; the tick should be high during the DIV-th cycle that follows.
      reset1 = 1'b0;
      applyStimulus(4'b0000);
      n = 0;
      while (sample_tick !== 1'b1 && n < 3 * DIV) begin
         @(negedge clock1);
         n++;
      end
      checkOutput("first_tick_cycle", n + 1, DIV);
      n = 0;
      do begin
         @(negedge clock1);
         n++;
      end while (sample_tick !== 1'b1 && n < 3 * DIV);
      checkOutput("tick_period", n, DIV);

      // Clean press on channel 0.
      applyStimulus(4'b0001);
      expectEvent(0, 1'b1, cycle + LAT_MIN, cycle + LAT_MAX);
      waitCycles(LAT_MAX + 5);
      checkOutput("level_after_press0", int'(btn_level), 4'b0001);

      // Channel 1 bounces every 15 cycles, never stable for SS samples.
      for (int k = 0; k < 10; k++) begin
         buttons[1] = ~buttons[1];
         waitCycles(15);
      end
      buttons[1] = 1'b0;
      waitCycles(LAT_MAX + 5);
      checkOutput("level_after_bounce1", int'(btn_level), 4'b0001);

      // Channels 2 and 3 pressed together, then released together.
      applyStimulus(4'b1101);
      expectEvent(2, 1'b1, cycle + LAT_MIN, cycle + LAT_MAX);
      expectEvent(3, 1'b1, cycle + LAT_MIN, cycle + LAT_MAX);
      n = 0;
      while (btn_level[2] !== 1'b1 && n < LAT_MAX + 5) begin
         @(negedge clock1);
         n++;
      end
      checkOutput("simul_press_pulses", int'(btn_pressed), 4'b1100);
      checkOutput("simul_press_levels", int'(btn_level), 4'b1101);
      waitCycles(20);
      applyStimulus(4'b0001);
      expectEvent(2, 1'b0, cycle + LAT_MIN, cycle + LAT_MAX);
      expectEvent(3, 1'b0, cycle + LAT_MIN, cycle + LAT_MAX);
      n = 0;
      while (btn_level[2] !== 1'b0 && n < LAT_MAX + 5) begin
         @(negedge clock1);
         n++;
      end
      checkOutput("simul_release_pulses", int'(btn_released), 4'b1100);
      checkOutput("simul_release_levels", int'(btn_level), 4'b0001);

      // Release channel 0.
      applyStimulus(4'b0000);
      expectEvent(0, 1'b0, cycle + LAT_MIN, cycle + LAT_MAX);
      waitCycles(LAT_MAX + 5);
      checkOutput("level_after_release0", int'(btn_level), 4'b0000);

      // Reset part way through qualifying a press; the press restarts from zero.
      applyStimulus(4'b0001);
      waitCycles(25);
      reset1 = 1'b1;
      repeat (2) begin
         @(negedge clock1);
         checkOutput("midcount_reset_outputs", int'({btn_level, btn_pressed, btn_released, sample_tick}), 0);
      end
      reset1 = 1'b0;
      c = cycle;
      // Tick phase is known after reset: samples land SS*DIV cycles after release of reset.
      expectEvent(0, 1'b1, c + SS * DIV, c + SS * DIV);
`ifdef BTN_AUTOREPEAT_EN
      for (int k = 0; k < 4; k++)
         expectEvent(0, 1'b1, c + SS * DIV + 50 + 20 * k, c + SS * DIV + 50 + 20 * k);
      waitCycles(SS * DIV + 95);
      checkOutput("level_held_repeat", int'(btn_level), 4'b0001);
      applyStimulus(4'b0000);
      expectEvent(0, 1'b0, c + SS * DIV + 130, c + SS * DIV + 130);
`else
      waitCycles(SS * DIV + 10);
      checkOutput("level_after_reset_press", int'(btn_level), 4'b0001);
      applyStimulus(4'b0000);
      expectEvent(0, 1'b0, cycle + LAT_MIN, cycle + LAT_MAX);
`endif
      waitCycles(LAT_MAX + 20);
      checkOutput("level_final", int'(btn_level), 4'b0000);
      checkOutput("pending_events", sbQueue.size(), 0);

      monitorOn = 1'b0;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
